sfifo_drain: RTL and testbench
==============================

# sfifo_drain

Read-side consumer for the memory execution unit's synchronous store FIFO. It pops committed store entries from the show-ahead FIFO read port and issues each one as a single-beat write request on the data-memory bus with a valid/ready handshake. It then waits for the bus acknowledge, with a bounded timeout, before retiring the entry. It reports drained status for fences and records a sticky error on bus error or timeout.

## Interface
Parameters:
- AW, 30: word-address width of an entry.
- TIMEOUT, 64: maximum cycles to wait for acknowledge; must be ≥2.

Ports:
- i_clk  in  1  clock; all state on rising edge.
- i_resetn  in  1  asynchronous, active-low reset.
- i_fifo_empty  in  1  FIFO empty flag.
- i_fifo_data  in  AW+36  show-ahead head entry {addr[AW-1:0], data[31:0], be[3:0]}.
- o_fifo_rd  out  1  pop strobe; combinational.
- i_pause  in  1  inhibit starting a new entry; does not abort one in flight.
- o_req_valid  out  1  bus write request valid.
- o_req_addr  out  AW  registered word address.
- o_req_data  out  32  registered write data.
- o_req_be  out  4  registered byte enables.
- i_req_ready  in  1  bus accepts request.
- i_ack  in  1  write acknowledge.
- i_ack_err  in  1  error qualifier, sampled only with i_ack.
- o_drained  out  1  FIFO empty and FSM in IDLE.
- o_err  out  1  sticky error flag.
- o_err_addr  out  AW  address of the first errored entry.
- i_err_clr  in  1  clears o_err and o_err_addr.

## Operation
- **FSM states:** IDLE, REQ, WAIT.
- **load condition:**
  - load = ~i_fifo_empty & ~i_pause & (state==IDLE | (state==WAIT & ack_or_timeout)).
  - o_fifo_rd = load.
  - On load, i_fifo_data is registered into o_req_addr/data/be, and the next state is REQ.
- **IDLE:** stays in IDLE unless load.
- **REQ:**
  - o_req_valid=1.
  - Request fields are held stable until accepted.
  - On i_req_ready: next state WAIT, timeout counter cleared to 0.
- **WAIT:**
  - The counter increments each cycle without i_ack.
  - ack_or_timeout = i_ack | (counter == TIMEOUT-1).
  - On ack_or_timeout: the entry retires. Next state is REQ if load, else IDLE.
- **Error capture:**
  - Error event = (i_ack & i_ack_err) | (timeout & ~i_ack) in WAIT.
  - If o_err is 0, set o_err=1 and o_err_addr=o_req_addr.
  - Later errors do not overwrite; draining continues, entries are not retried.
- **Error clear:**
  - i_err_clr clears o_err and o_err_addr to 0.
  - If i_err_clr coincides with an error event, the event wins: o_err=1 with the new address.
- **Ignored inputs:**
  - i_ack in IDLE or REQ is ignored.
  - i_req_ready outside REQ is ignored.
- **Counter:** width $clog2(TIMEOUT); saturating is not needed because it is cleared on WAIT entry.
- **o_drained:** = (state==IDLE) & i_fifo_empty; combinational.
- **Reset:**
  - Asserting i_resetn low forces state IDLE, counter 0, all registered outputs 0, o_err 0.
  - An entry already popped and in flight is discarded.
  - o_fifo_rd is 0 while reset is asserted.

## Timing
- **Load to request:** a load in cycle N gives o_req_valid=1 in N+1.
- **Request to WAIT:** ready at N+1 gives WAIT in N+2.
- **Back-to-back:** earliest ack in N+2, with a same-cycle load of the next entry, gives the next o_req_valid at N+3. Peak throughput is one entry per 2 cycles.
- **Timeout:** with no ack, retire occurs in the TIMEOUT-th WAIT cycle, i.e. counter values 0..TIMEOUT-1.
- **i_pause:** effective in the same cycle; it gates o_fifo_rd combinationally.
- **Reset recovery:** after deassertion, the first load can occur in the first clock edge with i_resetn high.
- **Pop/read ordering:** exactly one o_fifo_rd pulse per entry, and never while i_fifo_empty=1.

## Test plan
- **Single store:**
  - Stimulus: one entry addr=0x100, data=0xDEADBEEF, be=0xF; ready immediate; ack 1 cycle after WAIT entry.
  - Required response: one pop; o_req_valid high exactly 1 cycle with those fields; o_drained returns high; o_err=0.
- **Back-pressure:**
  - Stimulus: i_req_ready held low 5 cycles.
  - Required response: o_req_valid and fields stable for 6 cycles; no additional pop.
- **Back-to-back:**
  - Stimulus: 4 entries queued; ready always; ack on first WAIT cycle.
  - Required response: 4 requests at cycles N+1, N+3, N+5, N+7 in FIFO order; 4 pops total.
- **Timeout:**
  - Stimulus: TIMEOUT=8, no ack, addr=0x2A.
  - Required response: retire after 8 WAIT cycles; o_err=1, o_err_addr=0x2A.
  - Follow-up: a later ack-error at 0x2B leaves o_err_addr=0x2A; i_err_clr sets o_err=0.
- **Pause/fence:**
  - Stimulus: i_pause asserted during WAIT with 2 entries queued.
  - Required response: the in-flight entry completes; no pop while paused; o_drained stays 0 until pause is released and both entries retire.
- **Reset mid-operation:**
  - Stimulus: i_resetn pulsed low in REQ.
  - Required response: o_req_valid drops immediately (asynchronous); after release, the next FIFO head is issued and the discarded entry is not reissued.

Source files
------------

// File: rtl/sfifo_drain.sv
// Store-FIFO drain: pops show-ahead FIFO entries and issues each as a single-beat
// bus write, waiting for acknowledge or timeout before retiring it.
module sfifo_drain #(
  parameter int AW      = 30,
  parameter int TIMEOUT = 64
) (
  input  logic           i_clk,
  input  logic           i_resetn,
  input  logic           i_fifo_empty,
  input  logic [AW+35:0] i_fifo_data,
  output logic           o_fifo_rd,
  input  logic           i_pause,
  output logic           o_req_valid,
  output logic [AW-1:0]  o_req_addr,
  output logic [31:0]    o_req_data,
  output logic [3:0]     o_req_be,
  input  logic           i_req_ready,
  input  logic           i_ack,
  input  logic           i_ack_err,
  output logic           o_drained,
  output logic           o_err,
  output logic [AW-1:0]  o_err_addr,
  input  logic           i_err_clr
);

  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_cnt;
  logic          w_timeout;
  logic          w_retire;
  logic          w_load;
  logic          w_err_evt;

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) r_state <= S_IDLE;
    else           r_state <= w_next;
  end

  // Pop is gated by reset so no entry is consumed while the FSM is held.
  always_comb begin
    w_next    = r_state;
    w_timeout = (r_state == S_WAIT) && (r_cnt == CW'(TIMEOUT - 1));
    w_retire  = (r_state == S_WAIT) && (i_ack || w_timeout);
    w_load    = i_resetn && !i_fifo_empty && !i_pause &&
                ((r_state == S_IDLE) || w_retire);
    w_err_evt = (r_state == S_WAIT) &&
                ((i_ack && i_ack_err) || (w_timeout && !i_ack));
    case (r_state)
      S_IDLE: if (w_load) w_next = S_REQ;
      S_REQ:  if (i_req_ready) w_next = S_WAIT;
      S_WAIT: if (w_retire) w_next = w_load ? S_REQ : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  assign o_fifo_rd   = w_load;
  assign o_req_valid = (r_state == S_REQ);
  assign o_drained   = (r_state == S_IDLE) && i_fifo_empty;

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      o_req_addr <= '0;
      o_req_data <= '0;
      o_req_be   <= '0;
    end else if (w_load) begin
      o_req_addr <= i_fifo_data[AW+35:36];
      o_req_data <= i_fifo_data[35:4];
      o_req_be   <= i_fifo_data[3:0];
    end
  end

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_cnt <= '0;
    end else if (r_state == S_REQ && i_req_ready) begin
      r_cnt <= '0;
    end else if (r_state == S_WAIT && !i_ack) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // A new error beats a simultaneous clear, even if the flag was already set.
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      o_err      <= 1'b0;
      o_err_addr <= '0;
    end else if (w_err_evt && (!o_err || i_err_clr)) begin
      o_err      <= 1'b1;
      o_err_addr <= o_req_addr;
    end else if (i_err_clr) begin
      o_err      <= 1'b0;
      o_err_addr <= '0;
    end
  end

endmodule

// File: tb/tb_sfifo_drain.sv
// Directed self-checking bench for sfifo_drain with a small behavioural show-ahead FIFO.
module tb_sfifo_drain;

  localparam int AW = 30;

  logic           clk = 1'b0;
  logic           resetn;
  logic           fifo_empty;
  logic [AW+35:0] fifo_data;
  logic           fifo_rd;
  logic           pause;
  logic           req_valid;
  logic [AW-1:0]  req_addr;
  logic [31:0]    req_data;
  logic [3:0]     req_be;
  logic           req_ready;
  logic           ack;
  logic           ack_err;
  logic           drained;
  logic           err;
  logic [AW-1:0]  err_addr;
  logic           err_clr;

  logic [AW+35:0] mem [0:31];
  int head = 0;
  int tail = 0;
  int pops = 0;
  int bad_pops = 0;
  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign fifo_empty = (head == tail);
  assign fifo_data  = mem[head[4:0]];

  always @(posedge clk) begin
    if (fifo_rd) begin
      if (fifo_empty) bad_pops <= bad_pops + 1;
      head <= head + 1;
      pops <= pops + 1;
    end
  end

  sfifo_drain #(.AW(AW), .TIMEOUT(8)) dut (
    .i_clk(clk), .i_resetn(resetn), .i_fifo_empty(fifo_empty), .i_fifo_data(fifo_data),
    .o_fifo_rd(fifo_rd), .i_pause(pause), .o_req_valid(req_valid), .o_req_addr(req_addr),
    .o_req_data(req_data), .o_req_be(req_be), .i_req_ready(req_ready), .i_ack(ack),
    .i_ack_err(ack_err), .o_drained(drained), .o_err(err), .o_err_addr(err_addr),
    .i_err_clr(err_clr)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] b);
    mem[tail[4:0]] = {a, d, b};
    tail++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    resetn = 1'b0; pause = 1'b0; req_ready = 1'b0; ack = 1'b0; ack_err = 1'b0; err_clr = 1'b0;
    cyc(); cyc();
    chk("rst_valid", 64'(req_valid), 64'd0);
    chk("rst_addr", 64'(req_addr), 64'd0);
    chk("rst_drained", 64'(drained), 64'd1);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_rd", 64'(fifo_rd), 64'd0);
    resetn = 1'b1;

    // Single store
    req_ready = 1'b1;
    push(30'h100, 32'hDEADBEEF, 4'hF);
    #1;
    chk("s1_rd", 64'(fifo_rd), 64'd1);
    cyc();
    chk("s1_valid", 64'(req_valid), 64'd1);
    chk("s1_addr", 64'(req_addr), 64'h100);
    chk("s1_data", 64'(req_data), 64'hDEADBEEF);
    chk("s1_be", 64'(req_be), 64'hF);
    chk("s1_rd_empty", 64'(fifo_rd), 64'd0);
    cyc();
    chk("s1_valid_1cyc", 64'(req_valid), 64'd0);
    chk("s1_wait_drained", 64'(drained), 64'd0);
    ack = 1'b1;
    cyc();
    ack = 1'b0;
    chk("s1_drained", 64'(drained), 64'd1);
    chk("s1_err", 64'(err), 64'd0);
    chk("s1_pops", 64'(pops), 64'd1);

    // Back-pressure: ready low for 5 cycles, second entry queued meanwhile
    req_ready = 1'b0;
    push(30'h200, 32'h11223344, 4'h3);
    #1;
    chk("bp_rd", 64'(fifo_rd), 64'd1);
    cyc();
    push(30'h201, 32'h55667788, 4'hC);
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("bp_valid", 64'(req_valid), 64'd1);
      chk("bp_addr", 64'(req_addr), 64'h200);
      chk("bp_data", 64'(req_data), 64'h11223344);
      chk("bp_be", 64'(req_be), 64'h3);
      chk("bp_rd", 64'(fifo_rd), 64'd0);
      chk("bp_pops", 64'(pops), 64'd2);
      if (i == 5) req_ready = 1'b1;
      cyc();
    end
    chk("bp_wait_valid", 64'(req_valid), 64'd0);
    chk("bp_wait_rd", 64'(fifo_rd), 64'd0);
    ack = 1'b1;
    #1;
    chk("bp_retire_rd", 64'(fifo_rd), 64'd1);
    cyc();
    ack = 1'b0;
    chk("bp2_valid", 64'(req_valid), 64'd1);
    chk("bp2_addr", 64'(req_addr), 64'h201);
    chk("bp2_be", 64'(req_be), 64'hC);
    cyc();
    ack = 1'b1;
    cyc();
    ack = 1'b0;
    chk("bp_drained", 64'(drained), 64'd1);
    chk("bp_pops_end", 64'(pops), 64'd3);

    // Back-to-back: 4 entries, ack held high (also ignored in IDLE/REQ)
    ack = 1'b1;
    for (int k = 0; k < 4; k++) push(30'h300 + 30'(k), 32'hA0 + 32'(k), 4'(k + 1));
    #1;
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("b2b_valid", 64'(req_valid), 64'd1);
      chk("b2b_addr", 64'(req_addr), 64'h300 + 64'(k));
      chk("b2b_data", 64'(req_data), 64'hA0 + 64'(k));
      cyc();
      chk("b2b_gap", 64'(req_valid), 64'd0);
    end
    cyc();
    ack = 1'b0;
    chk("b2b_drained", 64'(drained), 64'd1);
    chk("b2b_pops", 64'(pops), 64'd7);

    // Timeout at 0x2A: 8 WAIT cycles without ack
    push(30'h2A, 32'hCAFE0000, 4'h1);
    #1;
    cyc();
    chk("to_valid", 64'(req_valid), 64'd1);
    chk("to_addr", 64'(req_addr), 64'h2A);
    cyc();
    for (int i = 0; i < 8; i++) begin
      chk("to_waiting", 64'(drained), 64'd0);
      chk("to_err_early", 64'(err), 64'd0);
      cyc();
    end
    chk("to_drained", 64'(drained), 64'd1);
    chk("to_err", 64'(err), 64'd1);
    chk("to_err_addr", 64'(err_addr), 64'h2A);

    // Later ack-error at 0x2B must not overwrite the captured address
    push(30'h2B, 32'h0, 4'h2);
    #1;
    cyc(); cyc();
    ack = 1'b1; ack_err = 1'b1;
    cyc();
    ack = 1'b0; ack_err = 1'b0;
    chk("ae_err", 64'(err), 64'd1);
    chk("ae_err_addr", 64'(err_addr), 64'h2A);
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
    chk("clr_err", 64'(err), 64'd0);
    chk("clr_err_addr", 64'(err_addr), 64'd0);

    // Error event coinciding with clear: event wins with new address
    push(30'h2C, 32'h0, 4'h4);
    #1;
    cyc(); cyc();
    ack = 1'b1; ack_err = 1'b1; err_clr = 1'b1;
    cyc();
    ack = 1'b0; ack_err = 1'b0; err_clr = 1'b0;
    chk("evclr_err", 64'(err), 64'd1);
    chk("evclr_addr", 64'(err_addr), 64'h2C);
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
    chk("clr2_err", 64'(err), 64'd0);

    // Pause during WAIT with two entries queued
    push(30'h400, 32'h400, 4'hF);
    #1;
    cyc(); cyc();
    push(30'h401, 32'h401, 4'hF);
    push(30'h402, 32'h402, 4'hF);
    pause = 1'b1; ack = 1'b1;
    #1;
    chk("pz_rd_retire", 64'(fifo_rd), 64'd0);
    cyc();
    ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("pz_rd", 64'(fifo_rd), 64'd0);
      chk("pz_drained", 64'(drained), 64'd0);
      chk("pz_valid", 64'(req_valid), 64'd0);
      cyc();
    end
    pause = 1'b0;
    #1;
    chk("pz_release_rd", 64'(fifo_rd), 64'd1);
    cyc();
    chk("pz_addr1", 64'(req_addr), 64'h401);
    chk("pz_drained_busy", 64'(drained), 64'd0);
    cyc();
    ack = 1'b1;
    cyc();
    chk("pz_addr2", 64'(req_addr), 64'h402);
    chk("pz_valid2", 64'(req_valid), 64'd1);
    cyc();
    cyc();
    ack = 1'b0;
    chk("pz_drained_end", 64'(drained), 64'd1);
    chk("pz_pops", 64'(pops), 64'd13);

    // Reset while in REQ: entry 0x500 discarded, 0x501 issued next
    req_ready = 1'b0;
    push(30'h500, 32'h500, 4'h5);
    push(30'h501, 32'h501, 4'h6);
    #1;
    cyc();
    chk("rm_valid", 64'(req_valid), 64'd1);
    chk("rm_addr", 64'(req_addr), 64'h500);
    resetn = 1'b0;
    #1;
    chk("rm_valid_async", 64'(req_valid), 64'd0);
    chk("rm_rd_in_reset", 64'(fifo_rd), 64'd0);
    chk("rm_addr_async", 64'(req_addr), 64'd0);
    cyc();
    resetn = 1'b1;
    #1;
    chk("rm_rd_release", 64'(fifo_rd), 64'd1);
    cyc();
    chk("rm_valid2", 64'(req_valid), 64'd1);
    chk("rm_addr2", 64'(req_addr), 64'h501);
    chk("rm_be2", 64'(req_be), 64'h6);
    req_ready = 1'b1;
    cyc();
    ack = 1'b1;
    cyc();
    ack = 1'b0;
    chk("rm_drained", 64'(drained), 64'd1);
    chk("rm_pops", 64'(pops), 64'd15);
    chk("rm_err", 64'(err), 64'd0);
    chk("no_pop_when_empty", 64'(bad_pops), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
